// File: rtl/configurable_rtc.sv
// Parametrised hh:mm:ss real-time clock with second-tick prescaler, synchronous
// time load, registered carry pulses and a programmable alarm.
module configurable_rtc #(
  parameter int unsigned W        = 6,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned SEC_MAX  = 59,
  parameter int unsigned MIN_MAX  = 59,
  parameter int unsigned HR_MAX   = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] ld_hh,
  input  logic [W-1:0] ld_mm,
  input  logic [W-1:0] ld_ss,
  input  logic         alarm_set,
  input  logic [W-1:0] al_hh,
  input  logic [W-1:0] al_mm,
  input  logic [W-1:0] al_ss,
  input  logic         alarm_en,
  output logic [W-1:0] hh,
  output logic [W-1:0] mm,
  output logic [W-1:0] ss,
  output logic         sec_tick,
  output logic         mm_en,
  output logic         hh_en,
  output logic         day_wrap,
  output logic         alarm_hit,
  output logic         load_err
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0]  hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [W-1:0]  al_hh_q, al_hh_d, al_mm_q, al_mm_d, al_ss_q, al_ss_d;
  logic          sec_tick_q, sec_tick_d, mm_en_q, mm_en_d, hh_en_q, hh_en_d;
  logic          day_wrap_q, day_wrap_d, alarm_hit_q, alarm_hit_d, load_err_q, load_err_d;

  logic tick_c;
  logic ss_wrap_c, mm_wrap_c, hh_wrap_c;
  logic ld_hh_bad_c, ld_mm_bad_c, ld_ss_bad_c;
  logic al_hh_bad_c, al_mm_bad_c, al_ss_bad_c;

  // Qualifying conditions for the tick and the range checks on load/alarm fields
  always_comb begin
    tick_c      = en && (pre_q == PW'(TICK_DIV - 1));
    ss_wrap_c   = (ss_q == W'(SEC_MAX));
    mm_wrap_c   = (mm_q == W'(MIN_MAX));
    hh_wrap_c   = (hh_q == W'(HR_MAX));
    ld_hh_bad_c = (ld_hh > W'(HR_MAX));
    ld_mm_bad_c = (ld_mm > W'(MIN_MAX));
    ld_ss_bad_c = (ld_ss > W'(SEC_MAX));
    al_hh_bad_c = (al_hh > W'(HR_MAX));
    al_mm_bad_c = (al_mm > W'(MIN_MAX));
    al_ss_bad_c = (al_ss > W'(SEC_MAX));
  end

  // Next-state: load has priority over tick; alarm_set is independent of both
  always_comb begin
    pre_d       = pre_q;
    hh_d        = hh_q;
    mm_d        = mm_q;
    ss_d        = ss_q;
    al_hh_d     = al_hh_q;
    al_mm_d     = al_mm_q;
    al_ss_d     = al_ss_q;
    sec_tick_d  = 1'b0;
    mm_en_d     = 1'b0;
    hh_en_d     = 1'b0;
    day_wrap_d  = 1'b0;
    alarm_hit_d = 1'b0;
    load_err_d  = 1'b0;

    if (load) begin
      pre_d = '0;
      hh_d  = ld_hh_bad_c ? '0 : ld_hh;
      mm_d  = ld_mm_bad_c ? '0 : ld_mm;
      ss_d  = ld_ss_bad_c ? '0 : ld_ss;
      if (ld_hh_bad_c || ld_mm_bad_c || ld_ss_bad_c) load_err_d = 1'b1;
    end else if (tick_c) begin
      pre_d      = '0;
      sec_tick_d = 1'b1;
      if (ss_wrap_c) begin
        ss_d    = '0;
        mm_en_d = 1'b1;
        if (mm_wrap_c) begin
          mm_d    = '0;
          hh_en_d = 1'b1;
          if (hh_wrap_c) begin
            hh_d       = '0;
            day_wrap_d = 1'b1;
          end else begin
            hh_d = hh_q + W'(1);
          end
        end else begin
          mm_d = mm_q + W'(1);
        end
      end else begin
        ss_d = ss_q + W'(1);
      end
      // Compare the time being produced this edge against the stored alarm
      alarm_hit_d = alarm_en && (hh_d == al_hh_q) && (mm_d == al_mm_q) && (ss_d == al_ss_q);
    end else if (en) begin
      pre_d = pre_q + PW'(1);
    end

    if (alarm_set) begin
      al_hh_d = al_hh_bad_c ? '0 : al_hh;
      al_mm_d = al_mm_bad_c ? '0 : al_mm;
      al_ss_d = al_ss_bad_c ? '0 : al_ss;
      if (al_hh_bad_c || al_mm_bad_c || al_ss_bad_c) load_err_d = 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q       <= '0;
      hh_q        <= '0;
      mm_q        <= '0;
      ss_q        <= '0;
      al_hh_q     <= '0;
      al_mm_q     <= '0;
      al_ss_q     <= '0;
      sec_tick_q  <= 1'b0;
      mm_en_q     <= 1'b0;
      hh_en_q     <= 1'b0;
      day_wrap_q  <= 1'b0;
      alarm_hit_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      al_hh_q     <= al_hh_d;
      al_mm_q     <= al_mm_d;
      al_ss_q     <= al_ss_d;
      sec_tick_q  <= sec_tick_d;
      mm_en_q     <= mm_en_d;
      hh_en_q     <= hh_en_d;
      day_wrap_q  <= day_wrap_d;
      alarm_hit_q <= alarm_hit_d;
      load_err_q  <= load_err_d;
    end
  end

  assign hh        = hh_q;
  assign mm        = mm_q;
  assign ss        = ss_q;
  assign sec_tick  = sec_tick_q;
  assign mm_en     = mm_en_q;
  assign hh_en     = hh_en_q;
  assign day_wrap  = day_wrap_q;
  assign alarm_hit = alarm_hit_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_configurable_rtc.sv
// Directed bench for configurable_rtc: one instance at TICK_DIV=1 and one at
// TICK_DIV=4, both driven from the same stimulus.
module tb_configurable_rtc;

  localparam int unsigned W = 6;

  logic         clk = 1'b0;
  logic         reset, en, load, alarm_set, alarm_en;
  logic [W-1:0] ld_hh, ld_mm, ld_ss, al_hh, al_mm, al_ss;

  logic [W-1:0] hh1, mm1, ss1, hh4, mm4, ss4;
  logic         st1, me1, he1, dw1, ah1, le1;
  logic         st4, me4, he4, dw4, ah4, le4;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned pulses;

  always #5 clk = ~clk;

  configurable_rtc #(.W(W), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
    .alarm_set(alarm_set), .al_hh(al_hh), .al_mm(al_mm), .al_ss(al_ss),
    .alarm_en(alarm_en), .hh(hh1), .mm(mm1), .ss(ss1),
    .sec_tick(st1), .mm_en(me1), .hh_en(he1), .day_wrap(dw1),
    .alarm_hit(ah1), .load_err(le1)
  );

  configurable_rtc #(.W(W), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .en(en), .load(load),
    .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
    .alarm_set(alarm_set), .al_hh(al_hh), .al_mm(al_mm), .al_ss(al_ss),
    .alarm_en(alarm_en), .hh(hh4), .mm(mm4), .ss(ss4),
    .sec_tick(st4), .mm_en(me4), .hh_en(he4), .day_wrap(dw4),
    .alarm_hit(ah4), .load_err(le4)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges; returns at a falling edge, where inputs change and outputs are sampled
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; load = 1'b0; alarm_set = 1'b0; alarm_en = 1'b0;
    ld_hh = '0; ld_mm = '0; ld_ss = '0; al_hh = '0; al_mm = '0; al_ss = '0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic set_load(input int h, input int m, input int s);
    load = 1'b1; ld_hh = W'(h); ld_mm = W'(m); ld_ss = W'(s);
  endtask

  initial begin
    do_reset();
    // Reset state
    chk("rst_hh", 32'(hh1), 0);
    chk("rst_mm", 32'(mm1), 0);
    chk("rst_ss", 32'(ss1), 0);
    chk("rst_pulses", 32'({st1, me1, he1, dw1, ah1, le1}), 0);

    // 60 enabled edges at TICK_DIV=1: ss walks 0..59 then wraps once
    en = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      step(1);
      chk("t1_ss", 32'(ss1), 32'(k % 60));
      chk("t1_tick", 32'(st1), 1);
      if (me1) pulses++;
    end
    chk("t1_mm_en_count", pulses, 1);
    chk("t1_mm", 32'(mm1), 1);
    chk("t1_hh", 32'(hh1), 0);

    // Load 23:59:59 then one tick: full day wrap
    en = 1'b0; set_load(23, 59, 59);
    step(1);
    load = 1'b0;
    chk("t2_ld_hh", 32'(hh1), 23);
    chk("t2_ld_mm", 32'(mm1), 59);
    chk("t2_ld_ss", 32'(ss1), 59);
    chk("t2_ld_tick", 32'(st1), 0);
    en = 1'b1;
    step(1);
    en = 1'b0;
    chk("t2_time", 32'({hh1, mm1, ss1}), 0);
    chk("t2_pulses", 32'({st1, me1, he1, dw1}), 4'b1111);
    step(1);
    chk("t2_pulses_clear", 32'({st1, me1, he1, dw1}), 0);

    // TICK_DIV=4: prescaler divides and holds while en is low
    do_reset();
    en = 1'b1;
    step(8);
    chk("t3_ss_8", 32'(ss4), 2);
    step(2);
    chk("t3_ss_10", 32'(ss4), 2);
    en = 1'b0;
    step(3);
    chk("t3_ss_frozen", 32'(ss4), 2);
    chk("t3_tick_frozen", 32'(st4), 0);
    en = 1'b1;
    step(1);
    chk("t3_ss_pre3", 32'(ss4), 2);
    step(1);
    chk("t3_ss_resume", 32'(ss4), 3);
    chk("t3_tick_resume", 32'(st4), 1);

    // Alarm at 00:01:00 reached by counting, not by loading
    do_reset();
    alarm_set = 1'b1; al_hh = W'(0); al_mm = W'(1); al_ss = W'(0); alarm_en = 1'b1;
    set_load(0, 0, 58);
    step(1);
    alarm_set = 1'b0; load = 1'b0;
    chk("t4_ld_hit", 32'(ah1), 0);
    en = 1'b1;
    step(1);
    chk("t4_ss59", 32'(ss1), 59);
    chk("t4_hit59", 32'(ah1), 0);
    step(1);
    chk("t4_time", 32'({hh1, mm1, ss1}), 32'({6'd0, 6'd1, 6'd0}));
    chk("t4_hit", 32'(ah1), 1);
    chk("t4_mm_en", 32'(me1), 1);
    step(1);
    chk("t4_hit_clear", 32'(ah1), 0);
    set_load(0, 1, 0);
    step(1);
    load = 1'b0;
    chk("t4_reload_time", 32'({hh1, mm1, ss1}), 32'({6'd0, 6'd1, 6'd0}));
    chk("t4_reload_hit", 32'(ah1), 0);
    chk("t4_reload_tick", 32'(st1), 0);
    step(1);
    chk("t4_after_ss", 32'(ss1), 1);
    chk("t4_after_hit", 32'(ah1), 0);

    // Out-of-range fields load 0 and flag load_err
    en = 1'b0;
    set_load(5, 60, 10);
    step(1);
    load = 1'b0;
    chk("t5_hh", 32'(hh1), 5);
    chk("t5_mm", 32'(mm1), 0);
    chk("t5_ss", 32'(ss1), 10);
    chk("t5_err", 32'(le1), 1);
    step(1);
    chk("t5_err_clear", 32'(le1), 0);
    set_load(23, 59, 59);
    step(1);
    load = 1'b0;
    chk("t5_max_ok", 32'(le1), 0);
    chk("t5_max_hh", 32'(hh1), 23);
    alarm_set = 1'b1; al_hh = W'(24); al_mm = W'(0); al_ss = W'(0);
    step(1);
    alarm_set = 1'b0;
    chk("t5_alarm_err", 32'(le1), 1);

    // Asynchronous reset mid-count clears outputs before the next edge
    set_load(12, 34, 56);
    step(1);
    load = 1'b0; en = 1'b1;
    step(2);
    chk("t6_pre_ss4", 32'(ss4), 56);
    chk("t6_pre_ss1", 32'(ss1), 58);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_dut4", 32'({hh4, mm4, ss4, st4}), 0);
    chk("t6_async_dut1", 32'({hh1, mm1, ss1, st1}), 0);
    step(1);
    reset = 1'b0;
    step(3);
    chk("t6_resume_ss_3", 32'(ss4), 0);
    step(1);
    chk("t6_resume_ss_4", 32'(ss4), 1);
    chk("t6_resume_dut1", 32'(ss1), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
